div_iter: RTL and testbench

DIV_ITER -- requirements
Module: div_iter

---
 rtl/div_iter.sv | 118 +++++++++++
 tb/tb_div_iter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// Iterative 32-bit radix-2 restoring divider (signed/unsigned) with
// valid/ready handshakes on both sides: one quotient bit per cycle, 33-cycle latency.
module div_iter (
   input  logic        div_clk,
   input  logic        reset,
   input  logic        div_valid,
   output logic        div_ready,
   input  logic        div_signed,
   input  logic [31:0] x,
   input  logic [31:0] y,
   input  logic        div_flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] a_q, a_d;      // dividend magnitude, quotient bits shift in at the LSB
   logic [31:0] b_q, b_d;      // divisor magnitude
   logic [31:0] rem_q, rem_d;  // partial remainder
   logic        qneg_q, qneg_d;
   logic        rneg_q, rneg_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] rmd_q, rmd_d;

   logic [32:0] shifted, diff;
   logic        qbit;
   logic [31:0] qmag, rmag;

   // The partial remainder is always below the divisor, so bit 32 of the
   // difference acts as the borrow of the 33-bit compare.
   always_comb begin
      shifted = {rem_q, a_q[31]};
      diff    = shifted - {1'b0, b_q};
      qbit    = ~diff[32];
      qmag    = {a_q[30:0], qbit};
      rmag    = qbit ? diff[31:0] : shifted[31:0];
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      rem_d   = rem_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      quo_d   = quo_q;
      rmd_d   = rmd_q;
      case (state_q)
         IDLE: begin
            if (div_valid && !div_flush) begin
               state_d = CALC;
               a_d     = (div_signed && x[31]) ? -x : x;
               b_d     = (div_signed && y[31]) ? -y : y;
               qneg_d  = div_signed & (x[31] ^ y[31]);
               rneg_d  = div_signed & x[31];
               rem_d   = '0;
               cnt_d   = '0;
            end
         end
         CALC: begin
            a_d   = qmag;
            rem_d = rmag;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = DONE;
               // With a zero divisor every step subtracts nothing, so the
               // remainder already equals |x|; only the quotient is forced.
               quo_d   = (b_q == '0) ? '1 : (qneg_q ? -qmag : qmag);
               rmd_d   = rneg_q ? -rmag : rmag;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (div_flush) begin
         state_d = IDLE;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge div_clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         rem_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         quo_q   <= '0;
         rmd_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rem_q   <= rem_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         quo_q   <= quo_d;
         rmd_q   <= rmd_d;
      end
   end

   assign div_ready = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign quotient  = quo_q;
   assign remainder = rmd_q;

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: latency, sign handling, corner cases,
// backpressure, flush and asynchronous reset.
module tb_div_iter;
   logic        div_clk = 1'b0;
   logic        reset, div_valid, div_ready, div_signed, div_flush;
   logic        out_valid, out_ready;
   logic [31:0] x, y, quotient, remainder;
   int          checks = 0, errors = 0, cyc = 0;

   always #5 div_clk = ~div_clk;
   always @(posedge div_clk) cyc++;

   div_iter dut (
      .div_clk(div_clk), .reset(reset), .div_valid(div_valid), .div_ready(div_ready),
      .div_signed(div_signed), .x(x), .y(y), .div_flush(div_flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .remainder(remainder)
   );

   task tick;
      @(posedge div_clk);
      #1;
   endtask

   // Handshake one request, scramble operands afterwards, wait for out_valid.
   // Returns in cycle T+lat with the observed result; lat=1 is the cycle after T.
   task run_op(input logic sgn, input logic [31:0] xa, input logic [31:0] ya,
               output logic [31:0] q, output logic [31:0] r, output int lat, output int hs);
      div_valid = 1'b1; div_signed = sgn; x = xa; y = ya;
      hs = cyc;
      tick;
      div_valid = 1'b0; div_signed = ~sgn; x = $urandom; y = $urandom;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 40) begin
         tick;
         lat++;
      end
      q = quotient; r = remainder;
   endtask

   task test_reset;
      reset = 1'b1; div_valid = 1'b0; div_signed = 1'b0; div_flush = 1'b0;
      out_ready = 1'b1; x = '0; y = '0;
      #12;
      checks++; if (div_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", div_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
      checks++; if (quotient !== 32'h0 || remainder !== 32'h0) begin errors++;
         $display("FAIL rst_result: got %h/%h want 0/0", quotient, remainder); end
      #5 reset = 1'b0;
   endtask

   task test_basic;
      logic [31:0] q, r; int lat, hs;
      run_op(1'b0, 32'd100, 32'd7, q, r, lat, hs);
      checks++; if (lat !== 33) begin errors++; $display("FAIL basic_lat: got %0d want 33", lat); end
      checks++; if (q !== 32'd14 || r !== 32'd2) begin errors++;
         $display("FAIL basic_result: got %0d r %0d want 14 r 2", q, r); end
      tick;
      checks++; if (out_valid !== 1'b0 || div_ready !== 1'b1) begin errors++;
         $display("FAIL basic_release: got valid=%b ready=%b want 0/1", out_valid, div_ready); end
   endtask

   task test_signed;
      logic [31:0] q, r; int lat, hs;
      run_op(1'b1, 32'hFFFFFFF9, 32'd2, q, r, lat, hs);
      checks++; if (q !== 32'hFFFFFFFD || r !== 32'hFFFFFFFF) begin errors++;
         $display("FAIL signed_neg: got %h r %h want fffffffd r ffffffff", q, r); end
      tick;
      run_op(1'b0, 32'hFFFFFFF9, 32'd2, q, r, lat, hs);
      checks++; if (q !== 32'h7FFFFFFC || r !== 32'h1) begin errors++;
         $display("FAIL unsigned_big: got %h r %h want 7ffffffc r 1", q, r); end
      tick;
      run_op(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, q, r, lat, hs);  // -100 / -7
      checks++; if (q !== 32'd14 || r !== 32'hFFFFFFFE) begin errors++;
         $display("FAIL signed_negneg: got %h r %h want e r fffffffe", q, r); end
      tick;
   endtask

   task test_special;
      logic [31:0] q, r; int lat, hs;
      run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, q, r, lat, hs);
      checks++; if (q !== 32'h80000000 || r !== 32'h0) begin errors++;
         $display("FAIL overflow: got %h r %h want 80000000 r 0", q, r); end
      tick;
      run_op(1'b1, 32'h12345678, 32'h0, q, r, lat, hs);
      checks++; if (q !== 32'hFFFFFFFF || r !== 32'h12345678 || lat !== 33) begin errors++;
         $display("FAIL div0_signed: got %h r %h lat %0d want ffffffff r 12345678 lat 33", q, r, lat); end
      tick;
      run_op(1'b0, 32'h12345678, 32'h0, q, r, lat, hs);
      checks++; if (q !== 32'hFFFFFFFF || r !== 32'h12345678 || lat !== 33) begin errors++;
         $display("FAIL div0_unsigned: got %h r %h lat %0d want ffffffff r 12345678 lat 33", q, r, lat); end
      tick;
      run_op(1'b1, 32'h87654321, 32'h0, q, r, lat, hs);
      checks++; if (q !== 32'hFFFFFFFF || r !== 32'h87654321) begin errors++;
         $display("FAIL div0_negx: got %h r %h want ffffffff r 87654321", q, r); end
      tick;
   endtask

   task test_back_to_back;
      logic [31:0] q, r; int lat, hs1, hs2;
      run_op(1'b0, 32'd1000, 32'd10, q, r, lat, hs1);
      checks++; if (q !== 32'd100 || r !== 32'd0) begin errors++;
         $display("FAIL b2b_first: got %0d r %0d want 100 r 0", q, r); end
      tick;
      run_op(1'b1, 32'hFFFFFC18, 32'd10, q, r, lat, hs2);
      checks++; if (q !== 32'hFFFFFF9C || r !== 32'h0) begin errors++;
         $display("FAIL b2b_second: got %h r %h want ffffff9c r 0", q, r); end
      checks++; if (hs2 - hs1 !== 34) begin errors++;
         $display("FAIL b2b_cadence: got %0d want 34", hs2 - hs1); end
      tick;
   endtask

   task test_backpressure;
      logic [31:0] q, r; int lat, hs;
      out_ready = 1'b0;
      run_op(1'b0, 32'd50, 32'd6, q, r, lat, hs);
      checks++; if (q !== 32'd8 || r !== 32'd2) begin errors++;
         $display("FAIL bp_result: got %0d r %0d want 8 r 2", q, r); end
      for (int i = 0; i < 5; i++) begin
         div_valid = i[0]; div_signed = 1'b0; x = 32'd7; y = 32'd1;
         tick;
         checks++; if (out_valid !== 1'b1 || div_ready !== 1'b0 || quotient !== 32'd8 || remainder !== 32'd2) begin
            errors++;
            $display("FAIL bp_hold%0d: got valid=%b ready=%b %0d r %0d want 1/0 8 r 2",
                     i, out_valid, div_ready, quotient, remainder);
         end
      end
      div_valid = 1'b0; out_ready = 1'b1;
      tick;
      checks++; if (div_ready !== 1'b1 || out_valid !== 1'b0) begin errors++;
         $display("FAIL bp_release: got ready=%b valid=%b want 1/0", div_ready, out_valid); end
      run_op(1'b0, 32'd81, 32'd9, q, r, lat, hs);
      checks++; if (q !== 32'd9 || r !== 32'd0 || lat !== 33) begin errors++;
         $display("FAIL bp_next: got %0d r %0d lat %0d want 9 r 0 lat 33", q, r, lat); end
      tick;
   endtask

   task test_flush;
      logic [31:0] q, r; int lat, hs; logic seen;
      div_valid = 1'b1; div_signed = 1'b0; x = 32'd100; y = 32'd7;
      tick;
      div_valid = 1'b0;
      repeat (10) tick;
      div_flush = 1'b1;
      tick;
      div_flush = 1'b0;
      checks++; if (div_ready !== 1'b1 || out_valid !== 1'b0) begin errors++;
         $display("FAIL flush_calc: got ready=%b valid=%b want 1/0", div_ready, out_valid); end
      seen = 1'b0;
      repeat (40) begin tick; if (out_valid === 1'b1) seen = 1'b1; end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_calc_novalid: got %b want 0", seen); end
      div_valid = 1'b1; div_flush = 1'b1; x = 32'd9; y = 32'd3;
      tick;
      div_valid = 1'b0; div_flush = 1'b0;
      checks++; if (div_ready !== 1'b1) begin errors++; $display("FAIL flush_idle: got ready=%b want 1", div_ready); end
      seen = 1'b0;
      repeat (40) begin tick; if (out_valid === 1'b1) seen = 1'b1; end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_idle_novalid: got %b want 0", seen); end
      out_ready = 1'b0;
      run_op(1'b0, 32'd100, 32'd7, q, r, lat, hs);
      checks++; if (q !== 32'd14 || r !== 32'd2) begin errors++;
         $display("FAIL flush_after: got %0d r %0d want 14 r 2", q, r); end
      div_flush = 1'b1;
      tick;
      div_flush = 1'b0; out_ready = 1'b1;
      checks++; if (out_valid !== 1'b0 || div_ready !== 1'b1) begin errors++;
         $display("FAIL flush_done: got valid=%b ready=%b want 0/1", out_valid, div_ready); end
   endtask

   task test_reset_mid;
      logic [31:0] q, r; int lat, hs; logic seen;
      div_valid = 1'b1; div_signed = 1'b0; x = 32'd1000; y = 32'd3;
      tick;
      div_valid = 1'b0;
      repeat (20) tick;
      #2 reset = 1'b1;
      #1;
      checks++; if (div_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 32'h0) begin errors++;
         $display("FAIL rst_mid_async: got ready=%b valid=%b q=%h want 1/0/0", div_ready, out_valid, quotient); end
      tick;
      #3 reset = 1'b0;
      seen = 1'b0;
      repeat (40) begin tick; if (out_valid === 1'b1) seen = 1'b1; end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_novalid: got %b want 0", seen); end
      run_op(1'b1, 32'hFFFFFF9C, 32'd7, q, r, lat, hs);
      checks++; if (q !== 32'hFFFFFFF2 || r !== 32'hFFFFFFFE || lat !== 33) begin errors++;
         $display("FAIL rst_mid_next: got %h r %h lat %0d want fffffff2 r fffffffe lat 33", q, r, lat); end
      tick;
   endtask

   initial begin
      test_reset;
      test_basic;
      test_signed;
      test_special;
      test_back_to_back;
      test_backpressure;
      test_flush;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
